// File: rtl/mac_error_monitor.sv
// mac_error_monitor: in-system checker for the approximate multiplier/MAC.
// Accepts operand/result tuples, recomputes the exact product and MAC, and
// accumulates error statistics over a window of NUM_SAMPLES samples.
// Optional build macro MAC_ERR_SUM_EN enables the mac_err_sum accumulator;
// without it mac_err_sum is tied to zero.
module mac_error_monitor #(
    parameter int unsigned IN_W        = 16,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned SUM_W       = 48,
    parameter int unsigned NUM_SAMPLES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_a,
    input  logic [IN_W-1:0]      in_b,
    input  logic [ACC_W-1:0]     in_add,
    input  logic [2*IN_W-1:0]    approx_mul,
    input  logic [ACC_W-1:0]     approx_mac,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          sample_cnt,
    output logic [SUM_W-1:0]     err_sum,
    output logic [SUM_W-1:0]     prod_sum,
    output logic [2*IN_W-1:0]    max_err,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          mismatch_cnt,
    output logic [SUM_W-1:0]     mac_err_sum
);

    localparam int unsigned P_W = 2 * IN_W;
    localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             clear;
    logic [15:0]      acc_cnt;

    logic             s1_valid;
    logic [P_W-1:0]   s1_exact_mul;
    logic [P_W-1:0]   s1_approx_mul;
    logic [ACC_W-1:0] s1_exact_mac;
    logic [ACC_W-1:0] s1_approx_mac;

    logic [P_W-1:0]   exact_mul;
    logic [ACC_W-1:0] exact_mac;
    logic [P_W-1:0]   err;
    logic             sample_ok;

    // Adds into an accumulator, sticking at all-ones instead of wrapping.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W:0] total;
        total = {1'b0, acc} + {1'b0, inc};
        return total[SUM_W] ? '1 : total[SUM_W-1:0];
    endfunction

    // Handshake, window-open and exact arithmetic for the incoming tuple.
    always_comb begin
        accept    = in_valid & in_ready;
        clear     = start & ((state == S_IDLE) | (state == S_DONE));
        exact_mul = P_W'(in_a) * P_W'(in_b);
        exact_mac = ACC_W'(exact_mul) + in_add;
        err       = (s1_approx_mul > s1_exact_mul) ? (s1_approx_mul - s1_exact_mul)
                                                   : (s1_exact_mul - s1_approx_mul);
        sample_ok = (s1_approx_mul == s1_exact_mul) && (s1_approx_mac == s1_exact_mac);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && acc_cnt == LAST_IDX) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!s1_valid) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counts accepted samples so RUN knows when the window is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc_cnt <= '0;
        else if (clear)  acc_cnt <= '0;
        else if (accept) acc_cnt <= acc_cnt + 16'd1;
    end

    // Stage 1: capture the tuple together with its exact product and MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_exact_mul  <= '0;
            s1_approx_mul <= '0;
            s1_exact_mac  <= '0;
            s1_approx_mac <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_exact_mul  <= exact_mul;
                s1_approx_mul <= approx_mul;
                s1_exact_mac  <= exact_mac;
                s1_approx_mac <= approx_mac;
            end
        end
    end

    // Stage 2: fold the captured sample into the window statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt   <= '0;
            err_sum      <= '0;
            prod_sum     <= '0;
            max_err      <= '0;
            pass_cnt     <= '0;
            mismatch_cnt <= '0;
        end else if (clear) begin
            sample_cnt   <= '0;
            err_sum      <= '0;
            prod_sum     <= '0;
            max_err      <= '0;
            pass_cnt     <= '0;
            mismatch_cnt <= '0;
        end else if (s1_valid) begin
            sample_cnt <= sample_cnt + 16'd1;
            err_sum    <= sat_add(err_sum, SUM_W'(err));
            prod_sum   <= sat_add(prod_sum, SUM_W'(s1_exact_mul));
            if (err > max_err) max_err <= err;
            if (sample_ok) pass_cnt     <= pass_cnt + 16'd1;
            else           mismatch_cnt <= mismatch_cnt + 16'd1;
        end
    end

`ifdef MAC_ERR_SUM_EN
    logic [ACC_W-1:0] mac_err;

    // Absolute MAC error of the captured sample.
    always_comb begin
        mac_err = (s1_approx_mac > s1_exact_mac) ? (s1_approx_mac - s1_exact_mac)
                                                 : (s1_exact_mac - s1_approx_mac);
    end

    // Saturating accumulation of the MAC error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        mac_err_sum <= '0;
        else if (clear)    mac_err_sum <= '0;
        else if (s1_valid) mac_err_sum <= sat_add(mac_err_sum, SUM_W'(mac_err));
    end
`else
    assign mac_err_sum = '0;
`endif

endmodule

// File: doc/mac_error_monitor.md
Name: mac_error_monitor

Overview:
Hardware receiving end for the approximate MAC datapath. It accepts streamed operand/result tuples from the approximate multiplier/MAC under a valid/ready handshake and recomputes the exact product and MAC internally. It accumulates error statistics (total error, total product, max error, pass/mismatch counts) over a programmed sample window, then reports them. It replaces the software-side checking loop so the approximate MAC can be characterised in-system over long runs.

Parameters:
IN_W, 16, operand width; products are 2*IN_W bits.
ACC_W, 32, MAC addend/result width; must be >= 2*IN_W.
SUM_W, 48, width of the err_sum and prod_sum accumulators.
NUM_SAMPLES, 10, samples accepted per measurement window; range 1..65535.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; opens a new measurement window
in_valid  in  1  sample tuple valid
in_ready  out  1  monitor can accept a sample
in_a  in  IN_W  operand 1
in_b  in  IN_W  operand 2
in_add  in  ACC_W  MAC addend
approx_mul  in  2*IN_W  approximate product from the DUT
approx_mac  in  ACC_W  approximate MAC result from the DUT
busy  out  1  window in progress
done  out  1  window complete, statistics stable
sample_cnt  out  16  samples retired in the current window
err_sum  out  SUM_W  sum of |approx_mul - exact_mul|
prod_sum  out  SUM_W  sum of exact_mul
max_err  out  2*IN_W  largest |approx_mul - exact_mul| seen
pass_cnt  out  16  samples with product and MAC both exact
mismatch_cnt  out  16  samples with product or MAC wrong
mac_err_sum  out  SUM_W  sum of |approx_mac - exact_mac| (optional feature)

Behaviour:
- Reset, asynchronous (rst_n low): FSM to IDLE; in_ready, busy, done = 0; all counters and accumulators = 0; pipeline valid bits cleared. Reset mid-window discards the window entirely.
- FSM IDLE -> RUN on start. RUN -> DRAIN when the NUM_SAMPLES-th sample is accepted. DRAIN -> DONE when the pipeline is empty. DONE -> RUN on start.
- On IDLE->RUN or DONE->RUN, all statistics clear in the same cycle. start is ignored in RUN and DRAIN.
- busy = 1 in RUN and DRAIN. done = 1 only in DONE and holds until the next start.
- in_ready = 1 only in RUN. A sample is accepted on a rising clk edge with in_valid & in_ready. in_valid while in_ready = 0 is ignored; no stall is imposed on the source.
- Stage 1 (accept edge): register inputs; exact_mul = in_a*in_b (unsigned, 2*IN_W bits); exact_mac = (exact_mul + in_add) mod 2^ACC_W.
- Stage 2 (next edge): err = absolute difference between approx_mul and exact_mul, unsigned 2*IN_W bits. Update err_sum, prod_sum, max_err (strictly greater replaces), pass_cnt or mismatch_cnt, and sample_cnt.
- Statistics reflect a sample 2 edges after its acceptance. done rises on the edge after the last sample retires.
- err_sum, prod_sum and mac_err_sum saturate at all-ones; they never wrap.
- pass_cnt + mismatch_cnt == sample_cnt at all times.
- Back-to-back samples: one accepted per cycle, sustained.

Optional Feature:
MAC_ERR_SUM_EN: when defined, stage 2 also adds |approx_mac - exact_mac| (ACC_W bits, unsigned) into mac_err_sum, with the same saturation rule. When undefined, mac_err_sum is tied to 0 and no MAC-error logic is built. Pass/mismatch classification uses the MAC compare in both builds.

Test Plan:
- Reset, then start; send a=3, b=5, add=1, approx_mul=15, approx_mac=16 -> after 2 edges: pass_cnt=1, err_sum=0, prod_sum=15, max_err=0.
- Send a=3, b=5, approx_mul=13, then a=3, b=5, approx_mul=17 -> err_sum=4, max_err=2, mismatch_cnt=2.
- NUM_SAMPLES=10, in_valid held high -> in_ready drops after the 10th accept, done rises 2 edges later, sample_cnt=10; a start then clears all statistics and reasserts in_ready.
- SUM_W=32: two samples with a=b=0xFFFF and exact approx_mul -> prod_sum saturates at 0xFFFFFFFF.
- MAC_ERR_SUM_EN defined: a=2, b=2, add=0xFFFFFFFF, approx_mac=5 -> exact_mac=3 (wrapped), mac_err_sum=2, mismatch_cnt=1. With the macro undefined, mac_err_sum=0.
- Assert rst_n low after 4 accepts -> all outputs 0 immediately; after release, FSM in IDLE with in_ready=0 until start.
